// File: rtl/fft16_output_reorder.sv
// fft16_output_reorder: ping-pong bit-reversal reorder buffer for 16-point FFT output; FFT_REORDER_CONJ_EN selects conjugated (saturated) output
module fft16_output_reorder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_r,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic [W-1:0] out_im,
  output logic         out_last,
  output logic         overflow
);
  typedef enum logic {IDLE, READ} state_t;
  logic [2*W-1:0] mem [2][16];
  logic [1:0] full, full_set, full_clr, full_nx;
  logic [3:0] wi, ri, ri_nx;
  logic wb, rb, rb_nx, wr, wr_last, rd, rd_last;
  state_t state, state_nx;
  logic [2*W-1:0] rd_word;
  logic [W-1:0] rd_im;
  assign in_ready  = ~full[wb];
  assign wr        = in_valid & in_ready;
  assign wr_last   = wr & (wi == 4'd15);
  assign out_valid = state == READ;
  assign rd        = out_valid & out_ready;
  assign rd_last   = rd & (ri == 4'd15);
  assign full_set  = wr_last ? (wb ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr  = rd_last ? (rb ? 2'b10 : 2'b01) : 2'b00;
  assign full_nx   = (full | full_set) & ~full_clr;
  // sample storage at the bit-reversed slot; contents survive reset on purpose
  always_ff @(posedge clk)
    if (wr) mem[wb][{wi[0], wi[1], wi[2], wi[3]}] <= {in_r, in_im};
  // write index, write bank, bank full flags and sticky drop flag
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      full     <= 2'b00;
      wi       <= 4'd0;
      wb       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      full     <= full_nx;
      wi       <= wr ? wi + 4'd1 : wi;
      wb       <= wb ^ wr_last;
      overflow <= overflow | (in_valid & ~in_ready);
    end
  // read FSM state, read index and read bank
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      state <= IDLE;
      ri    <= 4'd0;
      rb    <= 1'b0;
    end else begin
      state <= state_nx;
      ri    <= ri_nx;
      rb    <= rb_nx;
    end
  // next read state; looking at full_nx lets a bank that completes this cycle start reading with no bubble
  always_comb begin
    state_nx = state;
    ri_nx    = ri;
    rb_nx    = rb;
    if (state == IDLE) begin
      state_nx = full_nx[rb] ? READ : IDLE;
      ri_nx    = 4'd0;
    end else if (rd) begin
      ri_nx = ri + 4'd1;
      if (rd_last) begin
        rb_nx    = ~rb;
        state_nx = full_nx[~rb] ? READ : IDLE;
      end
    end
  end
  assign rd_word = mem[rb][ri];
`ifdef FFT_REORDER_CONJ_EN
  assign rd_im = (rd_word[W-1:0] == {1'b1, {(W-1){1'b0}}}) ? {1'b0, {(W-1){1'b1}}} : (~rd_word[W-1:0] + 1'b1);
`else
  assign rd_im = rd_word[W-1:0];
`endif
  assign out_r    = out_valid ? rd_word[2*W-1:W] : '0;
  assign out_im   = out_valid ? rd_im : '0;
  assign out_last = out_valid & (ri == 4'd15);
endmodule

// File: tb/tb_fft16_output_reorder.sv
// tb_fft16_output_reorder: scoreboard bench for the FFT output reorder buffer
module tb_fft16_output_reorder;
  logic clk = 1'b0;
  logic clear = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] in_r = '0;
  logic [7:0] in_im = '0;
  logic in_ready, out_valid, out_last, overflow;
  logic [7:0] out_r, out_im;
  always #5 clk = ~clk;
  fft16_output_reorder dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_im(out_im), .out_last(out_last), .overflow(overflow)
  );
  int vecs = 0;
  int errs = 0;
  logic [16:0] sb[$];
  int unsigned cyc = 0;
  int unsigned hs_t[$];
  logic [7:0] fr_r[16];
  logic [7:0] fr_im[16];
  int cnt = 0;
  int waited = 0;
  int ord[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int pat[4] = '{1, 0, 0, 1};
  logic stall = 1'b0;
  logic [16:0] held, got, exp_v;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] xim(input logic [7:0] v);
`ifdef FFT_REORDER_CONJ_EN
    return (v == 8'h80) ? 8'h7f : (~v + 8'd1);
`else
    return v;
`endif
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask
  // monitor: pops the scoreboard on every output handshake, checks hold and idle zeros
  always @(negedge clk) begin
    got = {out_last, out_r, out_im};
    if (stall && out_valid) check("hold", 32'(got), 32'(held));
    if (!out_valid) check("idle_zero", 32'(got), 32'd0);
    else if (out_ready) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_out: got %0h expected none", got);
      end else begin
        exp_v = sb.pop_front();
        check("out", 32'(got), 32'(exp_v));
        hs_t.push_back(cyc);
      end
    end
    stall = out_valid & ~out_ready;
    held = got;
  end
  task automatic put(input logic [7:0] r, input logic [7:0] im);
    int t = 0;
    in_valid = 1'b1;
    in_r = r;
    in_im = im;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      t++;
      waited = 1;
      @(negedge clk);
    end
    if (!in_ready) begin
      vecs++;
      errs++;
      $display("FAIL put_timeout: in_ready got 0 expected 1");
    end else begin
      fr_r[cnt] = r;
      fr_im[cnt] = im;
      cnt++;
      if (cnt == 16) begin
        for (int j = 0; j < 16; j++) sb.push_back({j == 15, fr_r[ord[j]], xim(fr_im[ord[j]])});
        cnt = 0;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 300) begin
      t++;
      @(negedge clk);
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
    check("drained_idle", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_outs", 32'({out_last, out_r, out_im}), 32'd0);
    clear = 1'b0;
    @(posedge clk);
    #1;
    // single frame: r = i, im = -i, with 1-cycle latency check
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) put(8'(i), 8'(-i));
    check("pre_last_valid", 32'(out_valid), 32'd0);
    put(8'd15, 8'(-15));
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();
    // streaming: 3 frames, no gaps
    hs_t.delete();
    waited = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 16; i++) put(8'(f * 40 + i * 2 + 1), 8'(100 - f * 16 - i));
    drain();
    check("stream_count", 32'(hs_t.size()), 32'd48);
    if (hs_t.size() == 48) check("stream_gapless", hs_t[47] - hs_t[0], 32'd47);
    check("stream_in_ready", 32'(waited), 32'd0);
    check("stream_overflow", 32'(overflow), 32'd0);
    // backpressure: two frames stored, third input dropped
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) put(8'(8'h40 + i), 8'(8'hC0 - 3 * i));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_no_ovf_yet", 32'(overflow), 32'd0);
    in_valid = 1'b1;
    in_r = 8'h77;
    in_im = 8'h77;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_overflow", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    drain();
    check("ovf_sticky", 32'(overflow), 32'd1);
    // output stall pattern 1,0,0,1 during a read; conj boundary values in this frame
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) put(8'(8'hA0 + i), (i == 0) ? 8'd5 : (i == 1) ? 8'h80 : 8'(i * 7));
    for (int i = 0; i < 40; i++) begin
      out_ready = pat[i % 4][0];
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();
    // clear mid-write
    for (int i = 0; i < 7; i++) put(8'(i + 50), 8'(i));
    #2 clear = 1'b1;
    #1;
    check("clr_w_in_ready", 32'(in_ready), 32'd1);
    check("clr_w_out_valid", 32'(out_valid), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
    clear = 1'b0;
    cnt = 0;
    @(posedge clk);
    #1;
    // clear mid-read
    for (int i = 0; i < 16; i++) put(8'(i + 20), 8'(i + 60));
    repeat (5) @(posedge clk);
    #2 clear = 1'b1;
    #1;
    check("clr_r_out_valid", 32'(out_valid), 32'd0);
    check("clr_r_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    clear = 1'b0;
    @(posedge clk);
    #1;
    // fresh frame after clear
    for (int i = 0; i < 16; i++) put(8'(8'hF0 - i), 8'(i * 9));
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
